efpga_cmd_issuer: RTL and testbench
===================================

# efpga_cmd_issuer

Upstream issue stage for the core's eFPGA custom-instruction path. Accepts one request at a time from the core over a valid/ready handshake and registers its operands onto the fabric input bus. It pulses the enable of the downstream eFPGA result FSM, waits for that FSM's one-cycle ready, and returns the captured result to the core over a valid/ready response channel. A watchdog converts a hung fabric (done never arriving) into an error response and flushes the pending transaction.

## Interface
- TIMEOUT_CYCLES, 1024: WAIT-state cycles before a timeout error; legal range 32..65535.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  issuer can accept a request
- req_op_i  in  2  operator: 00 A, 01 B, 10 C, 11 write
- req_delay_i  in  4  fixed fabric latency; 4'hF means wait for fabric done
- req_opa_i / req_opb_i / req_opc_i  in  32 each  operands
- efpga_opa_o / efpga_opb_o / efpga_opc_o  out  32 each  registered operands to the fabric
- en_o  out  1  one-cycle enable to the result FSM
- operator_o  out  2  registered operator to the result FSM
- delay_o  out  4  registered delay to the result FSM
- ready_i  in  1  result FSM ready, one-cycle pulse
- endresult_i  in  32  result FSM data, valid when ready_i is high
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  core accepts response
- rsp_data_o  out  32  result data
- rsp_err_o  out  1  response is a timeout error

## Operation
- States: IDLE, ISSUE, WAIT, RESP, FLUSH.
- Reset values: state IDLE; all outputs 0 except req_ready_o = 1.
- req_ready_o is high only in IDLE.
- IDLE, on req_valid_i: latch op, delay and the three operands into the output registers, then go to ISSUE.
- ISSUE: en_o = 1 for exactly this cycle; go to WAIT and clear the watchdog.
- operator_o, delay_o and efpga_op*_o stay stable from ISSUE until the next accepted request, because the result FSM samples them while busy.
- WAIT, ready_i = 1: rsp_data_o ← endresult_i, rsp_err_o ← 0, go to RESP.
- WAIT, no ready: increment the watchdog. When it reaches TIMEOUT_CYCLES-1: rsp_data_o ← 0, rsp_err_o ← 1, set the flush flag, go to RESP.
- ready_i and timeout in the same cycle: ready wins and a normal response is returned.
- RESP: rsp_valid_o = 1. rsp_data_o and rsp_err_o are held until rsp_ready_i.
- On the RESP handshake: go to FLUSH if the flush flag is set, else IDLE.
- RESP backpressure is unbounded.
- ready_i arriving while in RESP after a timeout is remembered. FLUSH then exits immediately.
- FLUSH: wait for ready_i, discard endresult_i, clear the flush flag, go to IDLE. This keeps the result FSM from being re-enabled while it is still busy.
- ready_i in IDLE or ISSUE is spurious and ignored.
- Reset mid-operation returns to IDLE and drops any transaction. The result FSM shares rst_n.

## Timing
- Request accepted at cycle A; en_o high at A+1.
- For delay d ≠ 15: ready_i arrives at A+d+3 and rsp_valid_o rises at A+d+4.
- For d = 15: latency tracks fabric done + 4.
- Back-to-back: the next request can be accepted the cycle after the RESP handshake. Minimum spacing is d+5 cycles.
- The watchdog is a 16-bit counter that saturates and is active only in WAIT.

## Structure
- Shared package efpga_pkg holds:
  - the state enum;
  - operator constants OP_A, OP_B, OP_C, OP_WRITE;
  - DELAY_WAIT_DONE = 4'hF;
  - EFPGA_DW = 32.
- Sub-module efpga_timeout_cnt provides the watchdog: clear, enable, terminal-count output, parameterised by TIMEOUT_CYCLES.

## Test plan
- Op 00, delay 3, opa = 32'h1234_5678, stub FSM returns opa → en_o high at A+1; rsp_valid_o at A+7 with data 32'h1234_5678, err 0.
- Op 11, delay 15, fabric done 20 cycles after en → operator_o = 11 held throughout; response data correct; req_ready_o low until the handshake.
- Delay 15, done never arrives, TIMEOUT_CYCLES = 32 → rsp_err_o = 1, data 0. After the handshake, FLUSH holds req_ready_o low until a late ready_i, then returns to IDLE.
- ready_i on the same cycle as terminal count → normal response with err 0; no FLUSH.
- rsp_ready_i held low 10 cycles → data stable, no new request accepted; the next request is accepted the cycle after the handshake.
- rst_n low during WAIT → all outputs at reset values next cycle; a fresh request completes normally.

Source files
------------

// File: rtl/efpga_pkg.sv
// Shared types and constants for the eFPGA custom-instruction issue path.
package efpga_pkg;

    localparam int EFPGA_DW = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_FLUSH
    } issuer_state_e;

    localparam logic [1:0] OP_A     = 2'b00;
    localparam logic [1:0] OP_B     = 2'b01;
    localparam logic [1:0] OP_C     = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b11;

    localparam logic [3:0] DELAY_WAIT_DONE = 4'hF;

endpackage

// File: rtl/efpga_timeout_cnt.sv
// Watchdog for the fabric wait: 16-bit saturating counter with clear,
// enable and a terminal-count flag at TIMEOUT_CYCLES-1.
module efpga_timeout_cnt
    import efpga_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [15:0] TC_VAL = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: clear wins, otherwise count up while enabled and not saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 16'd0;
        end else if (en_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/efpga_cmd_issuer.sv
// Issue stage for eFPGA custom instructions: accepts one core request,
// drives operands to the fabric, pulses the result FSM enable, and returns
// the result (or a timeout error) to the core. After a timeout the issuer
// holds off new requests until the still-busy result FSM reports ready.
module efpga_cmd_issuer
    import efpga_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_op_i,
    input  logic [3:0]          req_delay_i,
    input  logic [EFPGA_DW-1:0] req_opa_i,
    input  logic [EFPGA_DW-1:0] req_opb_i,
    input  logic [EFPGA_DW-1:0] req_opc_i,
    output logic [EFPGA_DW-1:0] efpga_opa_o,
    output logic [EFPGA_DW-1:0] efpga_opb_o,
    output logic [EFPGA_DW-1:0] efpga_opc_o,
    output logic                en_o,
    output logic [1:0]          operator_o,
    output logic [3:0]          delay_o,
    input  logic                ready_i,
    input  logic [EFPGA_DW-1:0] endresult_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [EFPGA_DW-1:0] rsp_data_o,
    output logic                rsp_err_o
);

    issuer_state_e       state_q, state_d;
    logic [EFPGA_DW-1:0] opa_q, opa_d;
    logic [EFPGA_DW-1:0] opb_q, opb_d;
    logic [EFPGA_DW-1:0] opc_q, opc_d;
    logic [1:0]          op_q, op_d;
    logic [3:0]          delay_q, delay_d;
    logic [EFPGA_DW-1:0] rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                flush_q, flush_d;      // result FSM still busy after a timeout
    logic                late_rdy_q, late_rdy_d; // its ready seen while still in RESP
    logic                wd_tc;

    efpga_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q == ST_ISSUE),
        .en_i  (state_q == ST_WAIT),
        .tc_o  (wd_tc)
    );

    // Next-state and register updates for the issue/wait/respond sequence.
    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        opc_d      = opc_q;
        op_d       = op_q;
        delay_d    = delay_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        flush_d    = flush_q;
        late_rdy_d = late_rdy_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    opa_d   = req_opa_i;
                    opb_d   = req_opb_i;
                    opc_d   = req_opc_i;
                    op_d    = req_op_i;
                    delay_d = req_delay_i;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A real result beats a coincident timeout.
                if (ready_i) begin
                    rsp_data_d = endresult_i;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (wd_tc) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    flush_d    = 1'b1;
                    late_rdy_d = 1'b0;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (flush_q && ready_i) begin
                    late_rdy_d = 1'b1;
                end
                if (rsp_ready_i) begin
                    state_d = flush_q ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (ready_i || late_rdy_q) begin
                    flush_d    = 1'b0;
                    late_rdy_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            opc_q      <= '0;
            op_q       <= 2'b00;
            delay_q    <= 4'h0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            flush_q    <= 1'b0;
            late_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            opc_q      <= opc_d;
            op_q       <= op_d;
            delay_q    <= delay_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            flush_q    <= flush_d;
            late_rdy_q <= late_rdy_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign en_o        = (state_q == ST_ISSUE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign efpga_opa_o = opa_q;
    assign efpga_opb_o = opb_q;
    assign efpga_opc_o = opc_q;
    assign operator_o  = op_q;
    assign delay_o     = delay_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_efpga_cmd_issuer.sv
// Directed bench for efpga_cmd_issuer; the bench plays the result FSM.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_efpga_cmd_issuer;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [3:0]  req_delay_i;
    logic [31:0] req_opa_i, req_opb_i, req_opc_i;
    logic [31:0] efpga_opa_o, efpga_opb_o, efpga_opc_o;
    logic        en_o;
    logic [1:0]  operator_o;
    logic [3:0]  delay_o;
    logic        ready_i;
    logic [31:0] endresult_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    efpga_cmd_issuer #(.TIMEOUT_CYCLES(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_delay_i (req_delay_i),
        .req_opa_i   (req_opa_i),
        .req_opb_i   (req_opb_i),
        .req_opc_i   (req_opc_i),
        .efpga_opa_o (efpga_opa_o),
        .efpga_opb_o (efpga_opb_o),
        .efpga_opc_o (efpga_opc_o),
        .en_o        (en_o),
        .operator_o  (operator_o),
        .delay_o     (delay_o),
        .ready_i     (ready_i),
        .endresult_i (endresult_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic req(input logic [1:0] op, input logic [3:0] dly, input logic [31:0] a);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_delay_i = dly;
        req_opa_i   = a;
        req_opb_i   = ~a;
        req_opc_i   = a ^ 32'h0F0F_0F0F;
    endtask

    initial begin
        rst_n = 1'b0; req_valid_i = 1'b0; req_op_i = 2'b00; req_delay_i = 4'h0;
        req_opa_i = '0; req_opb_i = '0; req_opc_i = '0;
        ready_i = 1'b0; endresult_i = '0; rsp_ready_i = 1'b0;
        nxt(); nxt();
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_en", {31'd0, en_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
        chk("rst_rsp_data", rsp_data_o, 32'd0);
        chk("rst_opa", efpga_opa_o, 32'd0);
        rst_n = 1'b1;

        // Op A, delay 3: en at A+1, ready at A+6, response at A+7.
        nxt();
        req(2'b00, 4'd3, 32'h1234_5678);
        chk("t1_ready_A", {31'd0, req_ready_o}, 32'd1);
        nxt(); req_valid_i = 1'b0;
        chk("t1_en_A1", {31'd0, en_o}, 32'd1);
        chk("t1_operator", {30'd0, operator_o}, 32'd0);
        chk("t1_delay", {28'd0, delay_o}, 32'd3);
        chk("t1_opa", efpga_opa_o, 32'h1234_5678);
        chk("t1_opb", efpga_opb_o, 32'hEDCB_A987);
        chk("t1_opc", efpga_opc_o, 32'h1D3B_5977);
        nxt();
        chk("t1_en_A2", {31'd0, en_o}, 32'd0);
        repeat (3) nxt();
        nxt();
        chk("t1_valid_A6", {31'd0, rsp_valid_o}, 32'd0);
        ready_i = 1'b1; endresult_i = 32'h1234_5678;
        nxt(); ready_i = 1'b0;
        chk("t1_valid_A7", {31'd0, rsp_valid_o}, 32'd1);
        chk("t1_data", rsp_data_o, 32'h1234_5678);
        chk("t1_err", {31'd0, rsp_err_o}, 32'd0);
        rsp_ready_i = 1'b1;
        nxt(); rsp_ready_i = 1'b0;
        chk("t1_idle", {31'd0, req_ready_o}, 32'd1);
        chk("t1_valid_drop", {31'd0, rsp_valid_o}, 32'd0);

        // Write op, wait-for-done, done 20 cycles after en.
        req(2'b11, 4'hF, 32'hA5A5_0011);
        nxt(); req_valid_i = 1'b0;
        chk("t2_en", {31'd0, en_o}, 32'd1);
        chk("t2_delay", {28'd0, delay_o}, 32'd15);
        for (int k = 2; k <= 20; k++) begin
            nxt();
            chk("t2_operator_held", {30'd0, operator_o}, 32'd3);
            chk("t2_req_ready_low", {31'd0, req_ready_o}, 32'd0);
            chk("t2_valid_low", {31'd0, rsp_valid_o}, 32'd0);
        end
        nxt();
        ready_i = 1'b1; endresult_i = 32'hCAFE_0011;
        nxt(); ready_i = 1'b0;
        chk("t2_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("t2_data", rsp_data_o, 32'hCAFE_0011);
        chk("t2_err", {31'd0, rsp_err_o}, 32'd0);
        chk("t2_operator_resp", {30'd0, operator_o}, 32'd3);
        rsp_ready_i = 1'b1;
        nxt(); rsp_ready_i = 1'b0;
        chk("t2_idle", {31'd0, req_ready_o}, 32'd1);

        // Done never arrives: timeout at A+33, error response at A+34, then FLUSH.
        req(2'b01, 4'hF, 32'h0000_0033);
        nxt(); req_valid_i = 1'b0;
        repeat (31) nxt();
        nxt();
        chk("t3_valid_A33", {31'd0, rsp_valid_o}, 32'd0);
        nxt();
        chk("t3_valid_A34", {31'd0, rsp_valid_o}, 32'd1);
        chk("t3_err", {31'd0, rsp_err_o}, 32'd1);
        chk("t3_data", rsp_data_o, 32'd0);
        nxt();
        chk("t3_valid_held", {31'd0, rsp_valid_o}, 32'd1);
        rsp_ready_i = 1'b1;
        nxt(); rsp_ready_i = 1'b0;
        chk("t3_flush_ready", {31'd0, req_ready_o}, 32'd0);
        chk("t3_flush_valid", {31'd0, rsp_valid_o}, 32'd0);
        req(2'b10, 4'd1, 32'h0000_0BAD);
        repeat (3) begin
            nxt();
            chk("t3_flush_hold", {31'd0, req_ready_o}, 32'd0);
            chk("t3_flush_no_en", {31'd0, en_o}, 32'd0);
        end
        ready_i = 1'b1;
        nxt(); ready_i = 1'b0; req_valid_i = 1'b0;
        chk("t3_idle", {31'd0, req_ready_o}, 32'd1);
        chk("t3_operator_kept", {30'd0, operator_o}, 32'd1);

        // Timeout, with the late ready arriving while still in RESP.
        req(2'b00, 4'hF, 32'h0000_0044);
        nxt(); req_valid_i = 1'b0;
        repeat (32) nxt();
        nxt();
        chk("t4_err", {31'd0, rsp_err_o}, 32'd1);
        ready_i = 1'b1;
        nxt(); ready_i = 1'b0;
        rsp_ready_i = 1'b1;
        nxt(); rsp_ready_i = 1'b0;
        chk("t4_flush", {31'd0, req_ready_o}, 32'd0);
        nxt();
        chk("t4_flush_exit", {31'd0, req_ready_o}, 32'd1);

        // Ready on the terminal-count cycle: normal response, no FLUSH.
        req(2'b10, 4'hF, 32'h0000_0055);
        nxt(); req_valid_i = 1'b0;
        repeat (31) nxt();
        nxt();
        ready_i = 1'b1; endresult_i = 32'h5555_AAAA;
        nxt(); ready_i = 1'b0;
        chk("t5_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("t5_err", {31'd0, rsp_err_o}, 32'd0);
        chk("t5_data", rsp_data_o, 32'h5555_AAAA);
        rsp_ready_i = 1'b1;
        nxt(); rsp_ready_i = 1'b0;
        chk("t5_no_flush", {31'd0, req_ready_o}, 32'd1);

        // Backpressure for 10 cycles with a new request pending.
        req(2'b10, 4'd0, 32'hA0A0_0001);
        nxt(); req_valid_i = 1'b0;
        nxt(); nxt();
        ready_i = 1'b1; endresult_i = 32'hBEEF_0002;
        nxt(); ready_i = 1'b0;
        chk("t6_valid", {31'd0, rsp_valid_o}, 32'd1);
        req(2'b01, 4'd5, 32'h0000_0777);
        repeat (10) begin
            nxt();
            chk("t6_data_stable", rsp_data_o, 32'hBEEF_0002);
            chk("t6_valid_held", {31'd0, rsp_valid_o}, 32'd1);
            chk("t6_no_accept", {31'd0, req_ready_o}, 32'd0);
            chk("t6_operator_held", {30'd0, operator_o}, 32'd2);
        end
        rsp_ready_i = 1'b1;
        nxt(); rsp_ready_i = 1'b0;
        chk("t6_accept_next", {31'd0, req_ready_o}, 32'd1);
        nxt(); req_valid_i = 1'b0;
        chk("t6_en", {31'd0, en_o}, 32'd1);
        chk("t6_new_operator", {30'd0, operator_o}, 32'd1);
        chk("t6_new_opa", efpga_opa_o, 32'h0000_0777);
        repeat (6) nxt();
        nxt();
        ready_i = 1'b1; endresult_i = 32'h0000_0777;
        nxt(); ready_i = 1'b0;
        chk("t6_valid2", {31'd0, rsp_valid_o}, 32'd1);
        chk("t6_data2", rsp_data_o, 32'h0000_0777);
        rsp_ready_i = 1'b1;
        nxt(); rsp_ready_i = 1'b0;

        // Reset during WAIT, then a fresh request.
        req(2'b11, 4'hF, 32'hDEAD_0007);
        nxt(); req_valid_i = 1'b0;
        nxt(); nxt(); nxt();
        rst_n = 1'b0;
        nxt(); rst_n = 1'b1;
        chk("t7_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("t7_en", {31'd0, en_o}, 32'd0);
        chk("t7_operator", {30'd0, operator_o}, 32'd0);
        chk("t7_delay", {28'd0, delay_o}, 32'd0);
        chk("t7_opa", efpga_opa_o, 32'd0);
        chk("t7_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("t7_data", rsp_data_o, 32'd0);
        chk("t7_err", {31'd0, rsp_err_o}, 32'd0);
        req(2'b01, 4'd2, 32'h1357_9BDF);
        nxt(); req_valid_i = 1'b0;
        chk("t7_en2", {31'd0, en_o}, 32'd1);
        nxt(); nxt(); nxt();
        nxt();
        ready_i = 1'b1; endresult_i = 32'h1357_9BDF;
        nxt(); ready_i = 1'b0;
        chk("t7_valid2", {31'd0, rsp_valid_o}, 32'd1);
        chk("t7_data2", rsp_data_o, 32'h1357_9BDF);
        rsp_ready_i = 1'b1;
        nxt(); rsp_ready_i = 1'b0;
        chk("t7_idle", {31'd0, req_ready_o}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
